// File: rtl/rom_based_temperature_converter.sv
// Celsius/Fahrenheit converter: a constant lookup table addressed by {unit_i, temperature_i},
// read through one output register (one-cycle latency, async active-low clear).
module rom_based_temperature_converter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] temperature_i,
  input  logic                  unit_i,
  output logic [DATA_WIDTH-1:0] temperature_o
);

  localparam int ROM_DEPTH = 1 << ADDR_WIDTH;

  // Table entry for a given address; the address MSB selects the direction.
  function automatic logic [DATA_WIDTH-1:0] rom_entry(input int unsigned addr);
    logic [31:0] w_t;
    logic [31:0] w_r;
    w_t = 32'(addr) & ((32'd1 << DATA_WIDTH) - 32'd1);
    if (addr < (32'd1 << DATA_WIDTH)) begin
      if (w_t <= 32'd100) w_r = (w_t * 32'd9 + 32'd2) / 32'd5 + 32'd32;
      else                w_r = 32'd212;
    end else begin
      if (w_t < 32'd32)       w_r = 32'd0;
      else if (w_t > 32'd212) w_r = 32'd100;
      else                    w_r = ((w_t - 32'd32) * 32'd5 + 32'd4) / 32'd9;
    end
    return w_r[DATA_WIDTH-1:0];
  endfunction

  logic [DATA_WIDTH-1:0] w_rom [ROM_DEPTH];
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] r_temp;

  if (ADDR_WIDTH != DATA_WIDTH + 1) begin : g_bad_params
    $error("ADDR_WIDTH must equal DATA_WIDTH+1");
  end

  for (genvar gi = 0; gi < ROM_DEPTH; gi++) begin : g_rom
    assign w_rom[gi] = rom_entry(gi);
  end

  assign w_addr = {unit_i, temperature_i};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_temp <= '0;
    else         r_temp <= w_rom[w_addr];
  end

  assign temperature_o = r_temp;

endmodule

// File: tb/tb_rom_based_temperature_converter.sv
// Directed bench for the temperature converter: vector table, model sweeps,
// round-trip property, and hand-written reset/latency sequences.
module tb_rom_based_temperature_converter;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [7:0] temperature_i = 8'd50;
  logic       unit_i = 1'b0;
  logic [7:0] temperature_o;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic       unit;
    logic [7:0] temp;
    logic [7:0] expected;
  } vec_t;

  vec_t vecs [20];

  rom_based_temperature_converter #(.ADDR_WIDTH(9), .DATA_WIDTH(8)) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .temperature_i (temperature_i),
    .unit_i        (unit_i),
    .temperature_o (temperature_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [7:0] exp_val);
    vectors++;
    if (temperature_o !== exp_val) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, temperature_o, exp_val);
    end else begin
      $display("ok   %s: %0d", name, temperature_o);
    end
  endtask

  // Drive between edges, sample just after the next rising edge.
  task automatic apply(input logic u, input logic [7:0] t);
    @(negedge clk_i);
    unit_i = u;
    temperature_i = t;
    @(posedge clk_i);
    #1;
  endtask

  // Round-half-up of C*1.8+32, written as floor((18C+5)/10)+32.
  function automatic logic [7:0] model_c2f(input int c);
    int r;
    if (c > 100) r = 212;
    else r = (18 * c + 5) / 10 + 32;
    return 8'(r);
  endfunction

  // Round-half-up of (F-32)*5/9, written as floor((10d+9)/18).
  function automatic logic [7:0] model_f2c(input int f);
    int r;
    if (f < 32) r = 0;
    else if (f > 212) r = 100;
    else r = (10 * (f - 32) + 9) / 18;
    return 8'(r);
  endfunction

  initial begin
    logic [7:0] f_val;

    vecs[0]  = '{1'b0, 8'd0,   8'd32};
    vecs[1]  = '{1'b0, 8'd1,   8'd34};
    vecs[2]  = '{1'b0, 8'd37,  8'd99};
    vecs[3]  = '{1'b0, 8'd40,  8'd104};
    vecs[4]  = '{1'b0, 8'd100, 8'd212};
    vecs[5]  = '{1'b0, 8'd101, 8'd212};
    vecs[6]  = '{1'b0, 8'd150, 8'd212};
    vecs[7]  = '{1'b0, 8'd255, 8'd212};
    vecs[8]  = '{1'b0, 8'd50,  8'd122};
    vecs[9]  = '{1'b1, 8'd32,  8'd0};
    vecs[10] = '{1'b1, 8'd33,  8'd1};
    vecs[11] = '{1'b1, 8'd41,  8'd5};
    vecs[12] = '{1'b1, 8'd98,  8'd37};
    vecs[13] = '{1'b1, 8'd212, 8'd100};
    vecs[14] = '{1'b1, 8'd0,   8'd0};
    vecs[15] = '{1'b1, 8'd31,  8'd0};
    vecs[16] = '{1'b1, 8'd213, 8'd100};
    vecs[17] = '{1'b1, 8'd255, 8'd100};
    vecs[18] = '{1'b1, 8'd100, 8'd38};
    vecs[19] = '{1'b1, 8'd50,  8'd10};

    // Reset held with clock running, then release.
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_hold", 8'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    check("after_release_before_edge", 8'd0);
    @(posedge clk_i);
    #1;
    check("first_edge_50C", 8'd122);

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i].unit, vecs[i].temp);
      check($sformatf("vec%0d u=%0d t=%0d", i, vecs[i].unit, vecs[i].temp), vecs[i].expected);
    end

    for (int c = 0; c < 256; c++) begin
      apply(1'b0, 8'(c));
      check($sformatf("c2f %0d", c), model_c2f(c));
    end
    for (int f = 0; f < 256; f++) begin
      apply(1'b1, 8'(f));
      check($sformatf("f2c %0d", f), model_f2c(f));
    end

    // C->F->C must return the original Celsius value.
    for (int c = 0; c <= 100; c++) begin
      apply(1'b0, 8'(c));
      f_val = temperature_o;
      apply(1'b1, f_val);
      check($sformatf("roundtrip %0d", c), 8'(c));
    end

    // Direction switch between edges: output holds until the next edge.
    apply(1'b0, 8'd100);
    check("switch_before", 8'd212);
    @(negedge clk_i);
    unit_i = 1'b1;
    #1;
    check("switch_hold", 8'd212);
    @(posedge clk_i);
    #1;
    check("switch_after", 8'd38);

    // Asynchronous reset mid-cycle.
    apply(1'b0, 8'd100);
    check("pre_async_reset", 8'd212);
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset_immediate", 8'd0);
    @(posedge clk_i);
    #1;
    check("async_reset_held_edge", 8'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("after_async_release", 8'd212);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
